jt12_bus_rx: RTL and testbench
==============================

Name: jt12_bus_rx

Overview:
CPU-bus responder for the YM2612-style 4-port interface (cs_n/wr_n/addr/din/dout). It is the receiving end of the testdata writer.
- Decodes address-port and data-port writes into complete register-write events {bank, reg, data}.
- Buffers events in a small FIFO and presents them on a valid/ready interface to the register file.
- Generates the busy flag and status byte returned to the CPU.

Parameters:
BUSY_CYCLES, 32, cen-qualified cycles busy stays asserted after an accepted data write (1..255)
FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16)

Ports:
clk  in  1  system clock
rst0  in  1  reset, asynchronous, active-high
cen  in  1  clock enable; all state advances only when cen=1
cs_n  in  1  chip select, active-low
wr_n  in  1  write strobe, active-low
addr  in  2  port select: [0]=0 address port, [0]=1 data port, [1]=bank
din  in  8  CPU write data
dout  out  8  status byte {busy, overflow, 4'b0, flag_b, flag_a}
flag_a  in  1  timer A flag from timer block
flag_b  in  1  timer B flag from timer block
busy  out  1  busy indication
ev_valid  out  1  register-write event available
ev_ready  in  1  consumer accepts event
ev_bank  out  1  event bank
ev_reg  out  8  event register address
ev_data  out  8  event data
overflow  out  1  sticky: a data write was dropped because the FIFO was full

Behaviour:
- Reset (rst0=1, async): FIFO empty, ev_valid=0, ev_bank/ev_reg/ev_data=0, reg_addr=0, bank_latch=0, busy counter=0, busy=0, overflow=0, dout=0. Reset mid-operation discards all pending events.
- Strobe detect: wr_act = ~cs_n & ~wr_n, registered on cen cycles as wr_act_d. A write is the rising edge wr_act & ~wr_act_d.
  - One event per strobe, regardless of how many cycles the strobe is held.
  - Strobes shorter than one cen period may be missed.
- Address write (addr[0]=0): reg_addr<=din, bank_latch<=addr[1]. No FIFO activity; busy unchanged.
- Data write (addr[0]=1): push {bank_latch, reg_addr, din} and load busy counter with BUSY_CYCLES.
  - The bank recorded is the one latched by the address write. addr[1] on the data write is ignored.
  - A data write with no prior address write uses reg_addr=0, bank=0.
  - reg_addr is retained after the data write, so consecutive data writes target the same register.
- Full FIFO: the push is dropped, overflow<=1 (sticky until rst0), and the busy counter is still reloaded.
  - Exception: if a pop occurs in the same cen cycle, the push is accepted.
- Writes while busy=1 are accepted (no drop on busy alone).
- Pop: on a cen cycle with ev_valid & ev_ready.
  - ev_* come directly from the FIFO head register, so they are valid in the cycle ev_valid rises.
  - First-word latency: ev_valid rises on the clk edge after the push edge (1 cen cycle).
  - ev_ready is ignored while ev_valid=0.
- Simultaneous push and pop on an empty FIFO: the new event appears next cycle; the FIFO never drops data.
- Busy counter: decrements by 1 per cen cycle while nonzero and saturates at 0. busy = (counter!=0) | ev_valid.
- dout: registered on each cen cycle and updated continuously, independent of cs_n/wr_n.
  - dout={busy, overflow, 4'b0, flag_b, flag_a}.
  - Bit7 reflects busy from the previous cycle.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from the MSB compare.
- When cen=0: no state change; outputs hold.

Decomposition:
- Shared package jt12_bus_pkg:
  - port decode constants: ADDR_PORT=1'b0, DATA_PORT=1'b1
  - event width EV_W=17
  - event field offsets (data [7:0], reg [15:8], bank [16])
  - status bit positions: BUSY=7, OVF=6, FLB=1, FLA=0
- Sub-module jt12_bus_fifo: synchronous FIFO with cen, rst0, push/pop, full/empty, and head output (parameters FIFO_DEPTH, EV_W).
- Top level contains the strobe detect, address latch, busy counter and status register.

Test Plan:
1. Address write 0x28 to port 0, then data write 0xF0 to port 1, ev_ready=1 -> one event {bank=0, reg=0x28, data=0xF0}; ev_valid pulses for 1 cen cycle; dout[7]=1 for BUSY_CYCLES cen cycles, then 0.
2. Address write 0xA4 to port 2, then data writes 0x22 and 0x33 to port 3 with ev_ready=0 -> two queued events {1,0xA4,0x22} and {1,0xA4,0x33}; raising ev_ready drains them in order over 2 cycles.
3. ev_ready=0, 5 data writes with FIFO_DEPTH=4 -> 4 events retained, the 5th dropped; overflow=1 and dout[6]=1; with ev_ready=1 exactly 4 events drain; overflow stays 1 until rst0.
4. wr_n held low for 10 cycles on one data write -> exactly one event pushed.
5. FIFO full and a data write coincides with a pop -> push accepted, overflow stays 0, FIFO remains full with the new event last.
6. rst0 pulsed with 3 pending events and busy=1 -> ev_valid=0, busy=0, dout=0x00 and overflow=0 immediately (async); the next address+data write produces a correct single event.

Source files
------------

// File: rtl/jt12_bus_pkg.sv
// Shared constants for the YM2612-style CPU bus receiver: port decode,
// event packing layout and status byte bit positions.
package jt12_bus_pkg;

  localparam logic ADDR_PORT = 1'b0;
  localparam logic DATA_PORT = 1'b1;

  localparam int EV_W        = 17;
  localparam int EV_DATA_LSB = 0;
  localparam int EV_REG_LSB  = 8;
  localparam int EV_BANK     = 16;

  localparam int ST_BUSY = 7;
  localparam int ST_OVF  = 6;
  localparam int ST_FLB  = 1;
  localparam int ST_FLA  = 0;

  function automatic logic [EV_W-1:0] pack_ev(input logic bank, input logic [7:0] rg,
                                              input logic [7:0] data);
    logic [EV_W-1:0] ev;
    ev = '0;
    ev[EV_BANK] = bank;
    ev[EV_REG_LSB +: 8] = rg;
    ev[EV_DATA_LSB +: 8] = data;
    return ev;
  endfunction

endpackage

// File: rtl/jt12_bus_fifo.sv
// Small synchronous event FIFO; head is combinational from storage (zero when empty).
// A push into a full FIFO is only taken when a pop happens in the same cen cycle.
module jt12_bus_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int EV_W       = 17
) (
  input  logic            clk,
  input  logic            rst0,
  input  logic            cen,
  input  logic            push,
  input  logic [EV_W-1:0] push_data,
  input  logic            pop,
  output logic [EV_W-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [EV_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            rd_en;
  logic            wr_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = cen & pop & ~empty;
  assign wr_en = cen & push & (~full | rd_en);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst0) begin
    if (rst0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/jt12_bus_rx.sv
// CPU bus responder: turns address/data port strobes into {bank, reg, data}
// events, queues them for the register file and drives busy/status back to the CPU.
module jt12_bus_rx
  import jt12_bus_pkg::*;
#(
  parameter int BUSY_CYCLES = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst0,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       flag_a,
  input  logic       flag_b,
  output logic       busy,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_bank,
  output logic [7:0] ev_reg,
  output logic [7:0] ev_data,
  output logic       overflow
);

  logic            wr_act;
  logic            wr_act_d;
  logic            wr_edge;
  logic            addr_wr;
  logic            data_wr;
  logic            pop;
  logic            full;
  logic            empty;
  logic [7:0]      reg_addr;
  logic            bank_latch;
  logic [7:0]      busy_cnt;
  logic [EV_W-1:0] ev_in;
  logic [EV_W-1:0] ev_head;
  logic [7:0]      status;

  assign wr_act  = ~cs_n & ~wr_n;
  assign wr_edge = wr_act & ~wr_act_d;
  assign addr_wr = cen & wr_edge & (addr[0] == ADDR_PORT);
  assign data_wr = cen & wr_edge & (addr[0] == DATA_PORT);
  assign pop     = cen & ev_valid & ev_ready;

  // Bank comes from the address write; addr[1] during the data write is ignored.
  assign ev_in = pack_ev(bank_latch, reg_addr, din);

  jt12_bus_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .EV_W       (EV_W)
  ) u_fifo (
    .clk       (clk),
    .rst0      (rst0),
    .cen       (cen),
    .push      (data_wr),
    .push_data (ev_in),
    .pop       (pop),
    .head      (ev_head),
    .full      (full),
    .empty     (empty)
  );

  assign ev_valid = ~empty;
  assign ev_bank  = ev_head[EV_BANK];
  assign ev_reg   = ev_head[EV_REG_LSB +: 8];
  assign ev_data  = ev_head[EV_DATA_LSB +: 8];
  assign busy     = (busy_cnt != 8'd0) | ev_valid;

  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_OVF]  = overflow;
    status[ST_FLB]  = flag_b;
    status[ST_FLA]  = flag_a;
  end

  always_ff @(posedge clk or posedge rst0) begin
    if (rst0) begin
      wr_act_d   <= 1'b0;
      reg_addr   <= 8'd0;
      bank_latch <= 1'b0;
      busy_cnt   <= 8'd0;
      overflow   <= 1'b0;
      dout       <= 8'd0;
    end else if (cen) begin
      wr_act_d <= wr_act;
      if (addr_wr) begin
        reg_addr   <= din;
        bank_latch <= addr[1];
      end
      // Reload happens even when the push is dropped on a full FIFO.
      if (data_wr) busy_cnt <= 8'(BUSY_CYCLES);
      else if (busy_cnt != 8'd0) busy_cnt <= busy_cnt - 8'd1;
      if (data_wr & full & ~pop) overflow <= 1'b1;
      dout <= status;
    end
  end

endmodule

// File: tb/tb_jt12_bus_rx.sv
// Directed bench for jt12_bus_rx: reset, event decode, queuing, overflow,
// long strobes, push-on-full-with-pop, cen hold and async reset mid-operation.
module tb_jt12_bus_rx;

  logic       clk = 1'b0;
  logic       rst0;
  logic       cen;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       flag_a;
  logic       flag_b;
  logic       busy;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_bank;
  logic [7:0] ev_reg;
  logic [7:0] ev_data;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  jt12_bus_rx #(
    .BUSY_CYCLES (32),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst0     (rst0),
    .cen      (cen),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .flag_a   (flag_a),
    .flag_b   (flag_b),
    .busy     (busy),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_bank  (ev_bank),
    .ev_reg   (ev_reg),
    .ev_data  (ev_data),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  // Drains the FIFO expecting consecutive data values starting at first.
  task automatic drain_seq(input string tag, input int first, input int count);
    int n;
    n = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ev_valid) begin
        check({tag, "_data"}, int'(ev_data), first + n);
        n++;
      end
      @(posedge clk); #1;
    end
    ev_ready = 1'b0;
    check({tag, "_count"}, n, count);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
  endtask

  initial begin
    int hi;
    rst0 = 1'b1; cen = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 2'd0; din = 8'd0;
    ev_ready = 1'b0; flag_a = 1'b0; flag_b = 1'b0;
    #1;
    check("rst_valid", int'(ev_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_reg", int'(ev_reg), 0);
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0;

    // 1: single event, one-cycle valid pulse, busy for BUSY_CYCLES on dout[7]
    ev_ready = 1'b1;
    cpu_wr(2'd0, 8'h28);
    cpu_wr(2'd1, 8'hF0);
    check("t1_valid", int'(ev_valid), 1);
    check("t1_ev", int'({ev_bank, ev_reg, ev_data}), 32'h028F0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("t1_pulse", int'(ev_valid), 0);
      if (dout[7]) hi++;
    end
    check("t1_busy_len", hi, 32);
    check("t1_busy_end", int'(busy), 0);

    // 2: bank 1, two queued events drained in order
    ev_ready = 1'b0;
    cpu_wr(2'd2, 8'hA4);
    cpu_wr(2'd3, 8'h22);
    cpu_wr(2'd3, 8'h33);
    check("t2_ev0", int'({ev_bank, ev_reg, ev_data}), 32'h1A422);
    ev_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_ev1", int'({ev_bank, ev_reg, ev_data}), 32'h1A433);
    check("t2_valid1", int'(ev_valid), 1);
    @(posedge clk); #1;
    check("t2_empty", int'(ev_valid), 0);

    // 3: overflow on the fifth write, sticky after draining
    ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cpu_wr(2'd1, 8'(i));
    check("t3_ovf", int'(overflow), 1);
    @(posedge clk); #1;
    check("t3_dout6", int'(dout[6]), 1);
    drain_seq("t3", 1, 4);
    check("t3_ovf_sticky", int'(overflow), 1);
    pulse_reset();
    check("t3_ovf_cleared", int'(overflow), 0);

    // 4: long strobe gives exactly one event; cen=0 holds state
    cpu_wr(2'd0, 8'h12);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; addr = 2'd1; din = 8'h77;
    repeat (10) @(posedge clk);
    #1 cs_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    check("t4_ev", int'({ev_bank, ev_reg, ev_data}), 32'h01277);
    cen = 1'b0; ev_ready = 1'b1; flag_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_hold_valid", int'(ev_valid), 1);
    check("t4_hold_dout0", int'(dout[0]), 0);
    cen = 1'b1;
    @(posedge clk); #1;
    check("t4_single", int'(ev_valid), 0);
    check("t4_flag_a", int'(dout[1:0]), 1);
    ev_ready = 1'b0; flag_a = 1'b0;
    pulse_reset();

    // 5: full FIFO, push coinciding with pop is accepted (no address write: reg 0)
    for (int i = 0; i < 4; i++) cpu_wr(2'd1, 8'(8'h10 + i));
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; addr = 2'd1; din = 8'h14; ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
    check("t5_ovf", int'(overflow), 0);
    check("t5_head", int'({ev_bank, ev_reg, ev_data}), 32'h00011);
    drain_seq("t5", 8'h11, 4);

    // 6: async reset with pending events
    for (int i = 0; i < 3; i++) cpu_wr(2'd1, 8'(8'h40 + i));
    @(posedge clk); #1;
    check("t6_pre_dout7", int'(dout[7]), 1);
    #2 rst0 = 1'b1;
    #1;
    check("t6_valid", int'(ev_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_dout", int'(dout), 0);
    check("t6_ovf", int'(overflow), 0);
    @(posedge clk); #1 rst0 = 1'b0;
    cpu_wr(2'd0, 8'h30);
    cpu_wr(2'd1, 8'h55);
    check("t6_ev", int'({ev_bank, ev_reg, ev_data}), 32'h03055);
    drain_seq("t6", 8'h55, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
